// File: rtl/tensor_element_unpacker_if.sv
// 32-bit word/element stream with last marker and valid/ready flow control.
interface tensor_element_unpacker_if;
    logic [31:0] data;
    logic        last;
    logic        valid;
    logic        ready;

    modport master (output data, output last, output valid, input ready);
    modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/tensor_element_unpacker.sv
// Splits byte-packed little-endian 32-bit words into 1..4 byte elements,
// emitting each zero- or sign-extended to 32 bits on a registered output stream.
module tensor_element_unpacker #(
    parameter bit SIGN_EXT = 1'b0
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [2:0]                        cfg_elem_bytes,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    output logic                              cfg_err,
    tensor_element_unpacker_if.slave          in_stream,
    tensor_element_unpacker_if.master         out_stream,
    output logic                              done,
    output logic [1:0]                        drop_bytes
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg;
    logic [2:0]  elem_reg;
    logic        last_seen_reg;
    logic [55:0] buf_reg;
    logic [2:0]  cnt_reg;
    logic [31:0] out_data_reg;
    logic        out_last_reg;
    logic        out_valid_reg;
    logic        cfg_err_reg;
    logic        done_reg;
    logic [1:0]  drop_reg;

    logic        run;
    logic        pop;
    logic        accept;
    logic        final_pop;
    logic        in_ready;
    logic [2:0]  cnt_ap;
    logic [55:0] shifted;
    logic [55:0] buf_next;
    logic [31:0] elem_ext;

    always_comb begin
        run       = (state_reg == RUN);
        pop       = run && (cnt_reg >= elem_reg) && (!out_valid_reg || out_stream.ready);
        cnt_ap    = pop ? (cnt_reg - elem_reg) : cnt_reg;
        // Combinational out_ready -> in_ready so E=4 sustains one word per cycle.
        in_ready  = run && !last_seen_reg && (cnt_ap < elem_reg);
        accept    = in_stream.valid && in_ready;
        final_pop = pop && last_seen_reg && (cnt_ap < elem_reg);
        shifted   = pop ? (buf_reg >> {elem_reg, 3'b000}) : buf_reg;
        buf_next  = shifted | ({24'd0, in_stream.data} << {cnt_ap, 3'b000});

        elem_ext = buf_reg[31:0];
        case (elem_reg)
            3'd1:    elem_ext = {{24{SIGN_EXT & buf_reg[7]}},  buf_reg[7:0]};
            3'd2:    elem_ext = {{16{SIGN_EXT & buf_reg[15]}}, buf_reg[15:0]};
            3'd3:    elem_ext = {{8{SIGN_EXT & buf_reg[23]}},  buf_reg[23:0]};
            default: elem_ext = buf_reg[31:0];
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            elem_reg      <= 3'd0;
            last_seen_reg <= 1'b0;
            buf_reg       <= 56'd0;
            cnt_reg       <= 3'd0;
            out_data_reg  <= 32'd0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
            done_reg      <= 1'b0;
            drop_reg      <= 2'd0;
        end else begin
            cfg_err_reg <= 1'b0;
            done_reg    <= 1'b0;
            drop_reg    <= 2'd0;

            // The output register drains on its own, even after returning to IDLE.
            if (pop) begin
                out_data_reg  <= elem_ext;
                out_last_reg  <= last_seen_reg && (cnt_ap < elem_reg);
                out_valid_reg <= 1'b1;
            end else if (out_stream.ready) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_elem_bytes != 3'd0 && cfg_elem_bytes <= 3'd4) begin
                            elem_reg      <= cfg_elem_bytes;
                            last_seen_reg <= 1'b0;
                            state_reg     <= RUN;
                        end else begin
                            cfg_err_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (final_pop) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                        drop_reg  <= cnt_ap[1:0];
                        buf_reg   <= 56'd0;
                        cnt_reg   <= 3'd0;
                    end else if (accept) begin
                        buf_reg <= buf_next;
                        cnt_reg <= cnt_ap + 3'd4;
                        if (in_stream.last) begin
                            last_seen_reg <= 1'b1;
                        end
                    end else if (pop) begin
                        buf_reg <= shifted;
                        cnt_reg <= cnt_ap;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cfg_ready        = (state_reg == IDLE);
    assign cfg_err          = cfg_err_reg;
    assign done             = done_reg;
    assign drop_bytes       = drop_reg;
    assign in_stream.ready  = in_ready;
    assign out_stream.data  = out_data_reg;
    assign out_stream.last  = out_last_reg;
    assign out_stream.valid = out_valid_reg;
endmodule

// File: tb/tb_tensor_element_unpacker.sv
// Directed bench: a zero-extending and a sign-extending unpacker share one stimulus
// stream; each row of the vector table is run to its done pulse and compared.
module tb_tensor_element_unpacker;
    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [2:0]  cfg_elem_bytes;
    logic        cfg_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_valid;
    logic        out_ready;

    logic        cfg_ready0, cfg_err0, done0;
    logic        cfg_ready1, cfg_err1, done1;
    logic [1:0]  drop0, drop1;

    tensor_element_unpacker_if in0 ();
    tensor_element_unpacker_if out0 ();
    tensor_element_unpacker_if in1 ();
    tensor_element_unpacker_if out1 ();

    assign in0.data  = in_data;
    assign in0.last  = in_last;
    assign in0.valid = in_valid;
    assign in1.data  = in_data;
    assign in1.last  = in_last;
    assign in1.valid = in_valid;
    assign out0.ready = out_ready;
    assign out1.ready = out_ready;

    tensor_element_unpacker #(.SIGN_EXT(1'b0)) dut0 (
        .clock          (clock),
        .reset_n        (reset_n),
        .cfg_elem_bytes (cfg_elem_bytes),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready0),
        .cfg_err        (cfg_err0),
        .in_stream      (in0.slave),
        .out_stream     (out0.master),
        .done           (done0),
        .drop_bytes     (drop0)
    );

    tensor_element_unpacker #(.SIGN_EXT(1'b1)) dut1 (
        .clock          (clock),
        .reset_n        (reset_n),
        .cfg_elem_bytes (cfg_elem_bytes),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready1),
        .cfg_err        (cfg_err1),
        .in_stream      (in1.slave),
        .out_stream     (out1.master),
        .done           (done1),
        .drop_bytes     (drop1)
    );

    // Packed arrays: index 0 is the rightmost 32-bit field of each concatenation.
    typedef struct packed {
        logic [2:0]        e;
        logic [2:0]        nwords;
        logic [3:0][31:0]  words;
        logic [3:0]        nout;
        logic [7:0][31:0]  exp_z;
        logic [7:0][31:0]  exp_s;
        logic [1:0]        drop;
        logic [15:0]       ready_pat;
        logic              full_rate;
    } vec_t;

    vec_t vecs [8];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        int          widx, oidx, first_acc, last_out;
        bit          got_done, stalled;
        logic [31:0] held;
        logic        held_last;
        v = vecs[idx];
        widx = 0; oidx = 0; first_acc = -1; last_out = -1;
        got_done = 1'b0; stalled = 1'b0; held = '0; held_last = 1'b0;

        @(negedge clock);
        cfg_elem_bytes = v.e;
        cfg_valid = 1'b1;
        #1 check($sformatf("v%0d cfg_ready", idx), 32'(cfg_ready0), 32'd1);
        @(negedge clock);
        cfg_valid = 1'b0;

        for (int cyc = 0; cyc < 200 && !(got_done && oidx >= int'(v.nout)); cyc++) begin
            if (cyc > 0) @(negedge clock);
            if (done0) begin
                check($sformatf("v%0d drop_bytes", idx), 32'(drop0), 32'(v.drop));
                check($sformatf("v%0d done_sext", idx), 32'(done1), 32'd1);
                got_done = 1'b1;
            end
            if (stalled) begin
                check($sformatf("v%0d hold_valid", idx), 32'(out0.valid), 32'd1);
                check($sformatf("v%0d hold_data", idx), out0.data, held);
                check($sformatf("v%0d hold_last", idx), 32'(out0.last), 32'(held_last));
            end
            in_valid  = (widx < int'(v.nwords));
            in_data   = in_valid ? v.words[widx[1:0]] : 32'd0;
            in_last   = in_valid && (widx == int'(v.nwords) - 1);
            out_ready = v.ready_pat[cyc % 16];
            #1;
            if (v.full_rate && in_valid)
                check($sformatf("v%0d in_ready_full_rate", idx), 32'(in0.ready), 32'd1);
            if (out0.valid && out_ready) begin
                if (oidx < int'(v.nout)) begin
                    check($sformatf("v%0d e%0d data", idx, oidx), out0.data, v.exp_z[oidx[2:0]]);
                    check($sformatf("v%0d e%0d data_sext", idx, oidx), out1.data, v.exp_s[oidx[2:0]]);
                    check($sformatf("v%0d e%0d last", idx, oidx), 32'(out0.last),
                          32'(oidx == int'(v.nout) - 1));
                end else begin
                    total++;
                    $display("FAIL v%0d extra_elem: got %h expected none", idx, out0.data);
                end
                $display("vec %0d elem %0d: data=%h sext=%h last=%b", idx, oidx, out0.data, out1.data, out0.last);
                last_out = cyc;
                oidx++;
            end
            stalled   = out0.valid && !out_ready;
            held      = out0.data;
            held_last = out0.last;
            if (in_valid && in0.ready) begin
                if (first_acc < 0) first_acc = cyc;
                widx++;
            end
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        check($sformatf("v%0d done_seen", idx), 32'(got_done), 32'd1);
        check($sformatf("v%0d elem_count", idx), 32'(oidx), 32'(v.nout));
        if (v.full_rate)
            check($sformatf("v%0d throughput", idx), 32'(last_out - first_acc), 32'(int'(v.nout) + 1));
        @(negedge clock);
        check($sformatf("v%0d idle_after", idx), 32'(cfg_ready0), 32'd1);
        check($sformatf("v%0d out_drained", idx), 32'(out0.valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{e: 3'd1, nwords: 3'd1, words: {96'd0, 32'h44332211}, nout: 4'd4,
                    exp_z: {128'd0, 32'h44, 32'h33, 32'h22, 32'h11},
                    exp_s: {128'd0, 32'h44, 32'h33, 32'h22, 32'h11},
                    drop: 2'd0, ready_pat: 16'hFFFF, full_rate: 1'b1};
        vecs[1] = '{e: 3'd3, nwords: 3'd2, words: {64'd0, 32'h88776655, 32'h44332211}, nout: 4'd2,
                    exp_z: {192'd0, 32'h665544, 32'h332211},
                    exp_s: {192'd0, 32'h665544, 32'h332211},
                    drop: 2'd2, ready_pat: 16'hFFFF, full_rate: 1'b0};
        vecs[2] = '{e: 3'd2, nwords: 3'd1, words: {96'd0, 32'h44332211}, nout: 4'd2,
                    exp_z: {192'd0, 32'h4433, 32'h2211},
                    exp_s: {192'd0, 32'h4433, 32'h2211},
                    drop: 2'd0, ready_pat: 16'hFFE7, full_rate: 1'b0};
        vecs[3] = '{e: 3'd4, nwords: 3'd4,
                    words: {32'h8F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100}, nout: 4'd4,
                    exp_z: {128'd0, 32'h8F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100},
                    exp_s: {128'd0, 32'h8F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100},
                    drop: 2'd0, ready_pat: 16'hFFFF, full_rate: 1'b1};
        vecs[4] = '{e: 3'd3, nwords: 3'd1, words: {96'd0, 32'hC0B0A090}, nout: 4'd1,
                    exp_z: {224'd0, 32'h00B0A090},
                    exp_s: {224'd0, 32'hFFB0A090},
                    drop: 2'd1, ready_pat: 16'hFFFF, full_rate: 1'b0};
        vecs[5] = '{e: 3'd3, nwords: 3'd3,
                    words: {32'd0, 32'h0C0B0A09, 32'h08070605, 32'h04030201}, nout: 4'd4,
                    exp_z: {128'd0, 32'h0C0B0A, 32'h090807, 32'h060504, 32'h030201},
                    exp_s: {128'd0, 32'h0C0B0A, 32'h090807, 32'h060504, 32'h030201},
                    drop: 2'd0, ready_pat: 16'hFFFF, full_rate: 1'b0};
        vecs[6] = '{e: 3'd1, nwords: 3'd1, words: {96'd0, 32'h7F80F001}, nout: 4'd4,
                    exp_z: {128'd0, 32'h7F, 32'h80, 32'hF0, 32'h01},
                    exp_s: {128'd0, 32'h0000007F, 32'hFFFFFF80, 32'hFFFFFFF0, 32'h00000001},
                    drop: 2'd0, ready_pat: 16'hFFFF, full_rate: 1'b0};
        vecs[7] = '{e: 3'd2, nwords: 3'd1, words: {96'd0, 32'h8001FFFE}, nout: 4'd2,
                    exp_z: {192'd0, 32'h8001, 32'hFFFE},
                    exp_s: {192'd0, 32'hFFFF8001, 32'hFFFFFFFE},
                    drop: 2'd0, ready_pat: 16'hFFFF, full_rate: 1'b0};

        reset_n = 1'b0; cfg_elem_bytes = 3'd0; cfg_valid = 1'b0;
        in_data = 32'd0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        in_valid = 1'b1;
        #1;
        check("reset out_valid", 32'(out0.valid), 32'd0);
        check("reset out_data", out0.data, 32'd0);
        check("reset done", 32'(done0), 32'd0);
        check("reset cfg_err", 32'(cfg_err0), 32'd0);
        check("reset cfg_ready", 32'(cfg_ready0), 32'd1);
        check("reset in_ready", 32'(in0.ready), 32'd0);
        in_valid = 1'b0;

        run_vec(0);
        run_vec(1);

        // Illegal sizes are rejected with a one-cycle pulse and leave the block idle.
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            cfg_elem_bytes = (k == 0) ? 3'd5 : ((k == 1) ? 3'd0 : 3'd7);
            cfg_valid = 1'b1;
            @(negedge clock);
            cfg_valid = 1'b0;
            in_valid = 1'b1;
            in_data = 32'hDEADBEEF;
            #1;
            $display("illegal cfg %0d: cfg_err=%b cfg_ready=%b", cfg_elem_bytes, cfg_err0, cfg_ready0);
            check($sformatf("bad%0d cfg_err", cfg_elem_bytes), 32'(cfg_err0), 32'd1);
            check($sformatf("bad%0d cfg_ready", cfg_elem_bytes), 32'(cfg_ready0), 32'd1);
            check($sformatf("bad%0d in_ready", cfg_elem_bytes), 32'(in0.ready), 32'd0);
            @(negedge clock);
            check($sformatf("bad%0d cfg_err_pulse", cfg_elem_bytes), 32'(cfg_err0), 32'd0);
            check($sformatf("bad%0d no_output", cfg_elem_bytes), 32'(out0.valid), 32'd0);
            in_valid = 1'b0;
        end

        for (int i = 2; i < 8; i++) run_vec(i);

        // Reset with a buffered tensor and a stalled output element.
        @(negedge clock);
        cfg_elem_bytes = 3'd1;
        cfg_valid = 1'b1;
        @(negedge clock);
        cfg_valid = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h7F80F001;
        in_last = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("pre_reset out_valid", 32'(out0.valid), 32'd1);
        check("pre_reset out_data", out1.data, 32'h00000001);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        in_valid = 1'b1;
        #1;
        $display("mid-tensor reset: out_valid=%b out_data=%h cfg_ready=%b", out0.valid, out0.data, cfg_ready0);
        check("mid_reset out_valid", 32'(out0.valid), 32'd0);
        check("mid_reset out_data", out0.data, 32'd0);
        check("mid_reset out_last", 32'(out0.last), 32'd0);
        check("mid_reset done", 32'(done0), 32'd0);
        check("mid_reset drop", 32'(drop0), 32'd0);
        check("mid_reset cfg_ready", 32'(cfg_ready0), 32'd1);
        check("mid_reset in_ready", 32'(in0.ready), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;

        run_vec(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
